// File: rtl/alu_funct_stage.sv
// -----------------------------------------------------------------------------
// alu_funct_stage
//
// Purpose:
//   Registered ALU funct generator that sits between ID and EX. It decodes the
//   instruction opcode (plus the SPECIAL funct field) into the ALU funct code
//   and holds the result in a one-entry valid/ready pipeline register.
//   The block also tracks the multi-cycle MULT/DIV unit. While that unit is
//   busy, it stalls new mul/div instructions and MFHI/MFLO reads.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   kill the held entry; no acceptance this cycle
//   in_valid   in   ID presents an instruction
//   in_ready   out  stage accepts the presented instruction this cycle
//   op         in   instruction opcode            [OP_W-1:0]
//   funct_in   in   instruction funct field       [FUNCT_W-1:0]
//   out_valid  out  funct_out holds a valid entry for EX
//   out_ready  in   EX takes the held entry
//   funct_out  out  registered ALU funct          [FUNCT_W-1:0]
//   md_busy    out  mul/div unit occupied
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_funct_stage #(
    parameter int OP_W       = 6,
    parameter int FUNCT_W    = 6,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FUNCT_W-1:0] funct_out,
    output logic               md_busy
);

    // -------------------------------------------------------------------------
    // Opcode encodings
    // -------------------------------------------------------------------------
    localparam logic [OP_W-1:0] OP_SPECIAL = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_JAL     = OP_W'(6'b000011);
    localparam logic [OP_W-1:0] OP_ADDI    = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_ADDIU   = OP_W'(6'b001001);
    localparam logic [OP_W-1:0] OP_SLTI    = OP_W'(6'b001010);
    localparam logic [OP_W-1:0] OP_SLTIU   = OP_W'(6'b001011);
    localparam logic [OP_W-1:0] OP_ANDI    = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OP_ORI     = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_XORI    = OP_W'(6'b001110);
    localparam logic [OP_W-1:0] OP_LUI     = OP_W'(6'b001111);
    localparam logic [OP_W-1:0] OP_LB      = OP_W'(6'b100000);
    localparam logic [OP_W-1:0] OP_LW      = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_LBU     = OP_W'(6'b100100);
    localparam logic [OP_W-1:0] OP_SB      = OP_W'(6'b101000);
    localparam logic [OP_W-1:0] OP_SW      = OP_W'(6'b101011);

    // -------------------------------------------------------------------------
    // ALU funct encodings
    // -------------------------------------------------------------------------
    localparam logic [FUNCT_W-1:0] F_NOP   = FUNCT_W'(6'b000000);
    localparam logic [FUNCT_W-1:0] F_MFHI  = FUNCT_W'(6'b010000);
    localparam logic [FUNCT_W-1:0] F_MFLO  = FUNCT_W'(6'b010010);
    localparam logic [FUNCT_W-1:0] F_MULT  = FUNCT_W'(6'b011000);
    localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(6'b011001);
    localparam logic [FUNCT_W-1:0] F_DIV   = FUNCT_W'(6'b011010);
    localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'(6'b011011);
    localparam logic [FUNCT_W-1:0] F_ADD   = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] F_ADDU  = FUNCT_W'(6'b100001);
    localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'(6'b100100);
    localparam logic [FUNCT_W-1:0] F_OR    = FUNCT_W'(6'b100101);
    localparam logic [FUNCT_W-1:0] F_XOR   = FUNCT_W'(6'b100110);
    localparam logic [FUNCT_W-1:0] F_SLT   = FUNCT_W'(6'b101010);
    localparam logic [FUNCT_W-1:0] F_SLTU  = FUNCT_W'(6'b101011);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic               out_valid_q, out_valid_d;
    logic [FUNCT_W-1:0] funct_q,     funct_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;

    // -------------------------------------------------------------------------
    // Decode
    // -------------------------------------------------------------------------
    logic [FUNCT_W-1:0] funct_dec;

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        funct_dec = F_NOP;
        case (op)
            OP_SPECIAL:                                   funct_dec = funct_in;
            OP_LUI, OP_ORI, OP_JAL:                       funct_dec = F_OR;
            OP_LB, OP_LBU, OP_LW, OP_SB, OP_SW, OP_ADDIU: funct_dec = F_ADDU;
            OP_ADDI:                                      funct_dec = F_ADD;
            OP_ANDI:                                      funct_dec = F_AND;
            OP_XORI:                                      funct_dec = F_XOR;
            OP_SLTI:                                      funct_dec = F_SLT;
            OP_SLTIU:                                     funct_dec = F_SLTU;
            default:                                      funct_dec = F_NOP;
        endcase
    end

    // -------------------------------------------------------------------------
    // Instruction classes and hazard
    // -------------------------------------------------------------------------
    logic is_special;
    logic md_op;
    logic hilo_rd;
    logic hazard;

    assign is_special = (op == OP_SPECIAL);
    assign md_op      = is_special &&
                        ((funct_in == F_MULT) || (funct_in == F_MULTU) ||
                         (funct_in == F_DIV)  || (funct_in == F_DIVU));
    assign hilo_rd    = is_special &&
                        ((funct_in == F_MFHI) || (funct_in == F_MFLO));

    // Only instructions that touch the mul/div unit or HI/LO wait on it.
    // Everything else keeps flowing while the unit is busy.
    assign hazard = md_busy && in_valid && (md_op || hilo_rd);

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    logic accept;
    logic out_hs;

    // The slot is free if it is empty, or if it is draining this same cycle.
    // This gives full throughput when EX is ready.
    assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Flush overrides a pending out_ready, so a flushed entry never issues.
    assign out_hs   = out_valid_q && out_ready && !flush;

    // -------------------------------------------------------------------------
    // Pipeline register next state
    // -------------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        funct_d     = funct_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            funct_d     = funct_dec;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Mul/div busy counter
    // -------------------------------------------------------------------------
    logic held_is_mul;
    logic held_is_div;

    // Only a SPECIAL pass-through can yield a mul/div funct. The held funct
    // alone therefore identifies the class of the issuing instruction.
    assign held_is_mul = (funct_q == F_MULT) || (funct_q == F_MULTU);
    assign held_is_div = (funct_q == F_DIV)  || (funct_q == F_DIVU);

    // The counter loads when the instruction leaves toward EX, not when it is
    // accepted. A mul/div that gets flushed from the slot never starts the
    // unit. Flush leaves a running count alone because that op is in flight.
    always_comb begin
        cnt_d = cnt_q;
        if (out_hs && held_is_mul) begin
            cnt_d = MUL_LOAD;
        end else if (out_hs && held_is_div) begin
            cnt_d = DIV_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            funct_q     <= F_NOP;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            funct_q     <= funct_d;
            cnt_q       <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_valid = out_valid_q;
    assign funct_out = funct_q;
    // md_busy comes straight from the counter register. An asynchronous reset
    // drops it at once, without waiting for a clock edge.
    assign md_busy   = (cnt_q != '0);

endmodule
